// File: rtl/mem_stage_if.sv
// Data-memory request/done bus between the memory stage and the data memory.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_done;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_done, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_done, mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: issues at most one data-memory access per XM instruction,
// stalls upstream while it is outstanding and registers the MW pipe outputs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access outstanding; ALU/link/special ops complete here
// ST_WAIT | request issued, waiting for mem_done or the timeout
module mem_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        XM_valid,
    input  logic [15:0] XM_aluOut,
    input  logic [15:0] XM_writeData,
    input  logic [15:0] XM_pc_inc,
    input  logic [15:0] XM_specOps,
    input  logic        XM_memRead,
    input  logic        XM_memWrite,
    input  logic [1:0]  XM_regSrc,
    input  logic        XM_regWrite,
    input  logic [2:0]  XM_writeReg,
    input  logic        XM_halt,
    mem_stage_if.master bus,
    output logic        mem_busy,
    output logic        MW_valid,
    output logic        MW_regWrite,
    output logic        MW_halt,
    output logic        MW_err,
    output logic [15:0] MW_wbData,
    output logic [2:0]  MW_writeReg,
    output logic        halted
);
    // Counter only needs to reach TIMEOUT-1; the last WAIT cycle is the compare cycle.
    localparam int            CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          wr_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;

    logic          access;
    logic          misaligned;
    logic          issue;
    logic          timeout;
    logic [15:0]   wb_sel;

    assign access     = XM_valid & (XM_memRead | XM_memWrite) & ~halted;
    assign misaligned = XM_aluOut[0];
    assign issue      = (state == ST_IDLE) & access & ~misaligned;
    assign timeout    = (TIMEOUT != 0) && (state == ST_WAIT) && (cnt == TC);

    // Writeback value selection; mem_rdata is only meaningful while mem_done is high.
    always_comb begin
        wb_sel = XM_aluOut;
        case (XM_regSrc)
            2'b00:   wb_sel = XM_aluOut;
            2'b01:   wb_sel = bus.mem_rdata;
            2'b10:   wb_sel = XM_pc_inc;
            default: wb_sel = XM_specOps;
        endcase
    end

    // Request is a strobe in the issue cycle; address/data hold their issued values in WAIT.
    assign bus.mem_req   = issue;
    assign bus.mem_wr    = (state == ST_WAIT) ? wr_q    : (issue & XM_memWrite);
    assign bus.mem_addr  = (state == ST_WAIT) ? addr_q  : (issue ? XM_aluOut    : 16'h0000);
    assign bus.mem_wdata = (state == ST_WAIT) ? wdata_q : (issue ? XM_writeData : 16'h0000);

    // Upstream advances in the cycle that mem_done or the timeout arrives.
    assign mem_busy = issue | ((state == ST_WAIT) & ~bus.mem_done & ~timeout);

    // Access FSM, timeout counter and registered MW outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            wr_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            MW_valid    <= 1'b0;
            MW_regWrite <= 1'b0;
            MW_halt     <= 1'b0;
            MW_err      <= 1'b0;
            MW_wbData   <= 16'h0000;
            MW_writeReg <= 3'd0;
            halted      <= 1'b0;
        end else begin
            MW_valid    <= 1'b0;
            MW_regWrite <= 1'b0;
            MW_halt     <= 1'b0;
            MW_err      <= 1'b0;
            if (MW_halt) begin
                halted <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            MW_valid <= 1'b1;
                            MW_err   <= 1'b1;
                        end else begin
                            state   <= ST_WAIT;
                            cnt     <= '0;
                            wr_q    <= XM_memWrite;
                            addr_q  <= XM_aluOut;
                            wdata_q <= XM_writeData;
                        end
                    end else if (XM_valid && !halted) begin
                        MW_valid    <= 1'b1;
                        MW_regWrite <= XM_regWrite;
                        MW_halt     <= XM_halt;
                        MW_wbData   <= wb_sel;
                        MW_writeReg <= XM_writeReg;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus.mem_done) begin
                        state       <= ST_IDLE;
                        MW_valid    <= 1'b1;
                        MW_regWrite <= XM_regWrite & ~wr_q;
                        MW_wbData   <= wb_sel;
                        MW_writeReg <= XM_writeReg;
                    end else if (timeout) begin
                        state    <= ST_IDLE;
                        MW_valid <= 1'b1;
                        MW_err   <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT=4.
module tb_mem_stage;
    logic        clk;
    logic        rst;
    logic        XM_valid;
    logic [15:0] XM_aluOut;
    logic [15:0] XM_writeData;
    logic [15:0] XM_pc_inc;
    logic [15:0] XM_specOps;
    logic        XM_memRead;
    logic        XM_memWrite;
    logic [1:0]  XM_regSrc;
    logic        XM_regWrite;
    logic [2:0]  XM_writeReg;
    logic        XM_halt;
    logic        mem_busy;
    logic        MW_valid;
    logic        MW_regWrite;
    logic        MW_halt;
    logic        MW_err;
    logic [15:0] MW_wbData;
    logic [2:0]  MW_writeReg;
    logic        halted;

    int checks = 0;
    int errors = 0;
    int req_total;
    int busy_total;
    int req_snap;
    int busy_snap;

    mem_stage_if bus_if ();

    mem_stage #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .XM_valid     (XM_valid),
        .XM_aluOut    (XM_aluOut),
        .XM_writeData (XM_writeData),
        .XM_pc_inc    (XM_pc_inc),
        .XM_specOps   (XM_specOps),
        .XM_memRead   (XM_memRead),
        .XM_memWrite  (XM_memWrite),
        .XM_regSrc    (XM_regSrc),
        .XM_regWrite  (XM_regWrite),
        .XM_writeReg  (XM_writeReg),
        .XM_halt      (XM_halt),
        .bus          (bus_if.master),
        .mem_busy     (mem_busy),
        .MW_valid     (MW_valid),
        .MW_regWrite  (MW_regWrite),
        .MW_halt      (MW_halt),
        .MW_err       (MW_err),
        .MW_wbData    (MW_wbData),
        .MW_writeReg  (MW_writeReg),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running counts of request and busy cycles, sampled mid-cycle.
    initial begin
        req_total  = 0;
        busy_total = 0;
    end
    always @(negedge clk) begin
        if (bus_if.mem_req) req_total <= req_total + 1;
        if (mem_busy)       busy_total <= busy_total + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_xm();
        XM_valid     = 1'b0;
        XM_aluOut    = 16'h0000;
        XM_writeData = 16'h0000;
        XM_pc_inc    = 16'h0000;
        XM_specOps   = 16'h0000;
        XM_memRead   = 1'b0;
        XM_memWrite  = 1'b0;
        XM_regSrc    = 2'b00;
        XM_regWrite  = 1'b0;
        XM_writeReg  = 3'd0;
        XM_halt      = 1'b0;
    endtask

    initial begin
        clear_xm();
        bus_if.mem_done  = 1'b0;
        bus_if.mem_rdata = 16'h0000;
        rst = 1'b0;
        #12;
        chk("rst_mw_valid", MW_valid, 1'b0);
        chk("rst_mw_wb", MW_wbData, 16'h0000);
        chk("rst_busy", mem_busy, 1'b0);
        chk("rst_req", bus_if.mem_req, 1'b0);
        chk("rst_halted", halted, 1'b0);
        rst = 1'b1;
        tick();

        // ALU op
        XM_valid = 1'b1; XM_aluOut = 16'h1234; XM_regSrc = 2'b00;
        XM_regWrite = 1'b1; XM_writeReg = 3'd3;
        #1;
        chk("alu_busy", mem_busy, 1'b0);
        chk("alu_req", bus_if.mem_req, 1'b0);
        tick();
        chk("alu_mw_valid", MW_valid, 1'b1);
        chk("alu_mw_wb", MW_wbData, 16'h1234);
        chk("alu_mw_reg", MW_writeReg, 3'd3);
        chk("alu_mw_regwrite", MW_regWrite, 1'b1);
        chk("alu_mw_err", MW_err, 1'b0);
        clear_xm();
        tick();
        chk("bubble_valid", MW_valid, 1'b0);
        chk("bubble_regwrite", MW_regWrite, 1'b0);

        // Load at 0x0040, done in the third WAIT cycle
        req_snap = req_total; busy_snap = busy_total;
        XM_valid = 1'b1; XM_memRead = 1'b1; XM_aluOut = 16'h0040;
        XM_regSrc = 2'b01; XM_regWrite = 1'b1; XM_writeReg = 3'd5;
        #1;
        chk("ld_req", bus_if.mem_req, 1'b1);
        chk("ld_wr", bus_if.mem_wr, 1'b0);
        chk("ld_addr", bus_if.mem_addr, 16'h0040);
        chk("ld_busy0", mem_busy, 1'b1);
        tick();
        chk("ld_w1_req", bus_if.mem_req, 1'b0);
        chk("ld_w1_addr", bus_if.mem_addr, 16'h0040);
        chk("ld_w1_busy", mem_busy, 1'b1);
        chk("ld_w1_mw_valid", MW_valid, 1'b0);
        tick();
        chk("ld_w2_busy", mem_busy, 1'b1);
        tick();
        bus_if.mem_done = 1'b1; bus_if.mem_rdata = 16'hBEEF;
        #1;
        chk("ld_w3_busy", mem_busy, 1'b0);
        tick();
        bus_if.mem_done = 1'b0; bus_if.mem_rdata = 16'h0000;
        chk("ld_mw_valid", MW_valid, 1'b1);
        chk("ld_mw_wb", MW_wbData, 16'hBEEF);
        chk("ld_mw_regwrite", MW_regWrite, 1'b1);
        chk("ld_mw_reg", MW_writeReg, 3'd5);
        chk("ld_req_cycles", 16'(req_total - req_snap), 16'd1);
        chk("ld_busy_cycles", 16'(busy_total - busy_snap), 16'd3);
        clear_xm();

        // Store 0x00AA to 0x0010, done in one cycle, then a load immediately
        XM_valid = 1'b1; XM_memWrite = 1'b1; XM_aluOut = 16'h0010;
        XM_writeData = 16'h00AA; XM_regWrite = 1'b1; XM_writeReg = 3'd2;
        #1;
        chk("st_req", bus_if.mem_req, 1'b1);
        chk("st_wr", bus_if.mem_wr, 1'b1);
        chk("st_wdata", bus_if.mem_wdata, 16'h00AA);
        tick();
        bus_if.mem_done = 1'b1;
        #1;
        chk("st_w1_busy", mem_busy, 1'b0);
        chk("st_w1_addr", bus_if.mem_addr, 16'h0010);
        chk("st_w1_wr", bus_if.mem_wr, 1'b1);
        chk("st_w1_req", bus_if.mem_req, 1'b0);
        tick();
        bus_if.mem_done = 1'b0;
        chk("st_mw_valid", MW_valid, 1'b1);
        chk("st_mw_regwrite", MW_regWrite, 1'b0);
        clear_xm();
        XM_valid = 1'b1; XM_memRead = 1'b1; XM_aluOut = 16'h0020;
        XM_regSrc = 2'b01; XM_regWrite = 1'b1; XM_writeReg = 3'd6;
        #1;
        chk("b2b_req", bus_if.mem_req, 1'b1);
        chk("b2b_addr", bus_if.mem_addr, 16'h0020);
        tick();
        bus_if.mem_done = 1'b1; bus_if.mem_rdata = 16'h1111;
        tick();
        bus_if.mem_done = 1'b0; bus_if.mem_rdata = 16'h0000;
        chk("b2b_mw_wb", MW_wbData, 16'h1111);
        chk("b2b_mw_regwrite", MW_regWrite, 1'b1);
        clear_xm();

        // Misaligned load
        XM_valid = 1'b1; XM_memRead = 1'b1; XM_aluOut = 16'h0041;
        XM_regSrc = 2'b01; XM_regWrite = 1'b1; XM_writeReg = 3'd1;
        #1;
        chk("mis_req", bus_if.mem_req, 1'b0);
        chk("mis_busy", mem_busy, 1'b0);
        tick();
        chk("mis_mw_valid", MW_valid, 1'b1);
        chk("mis_mw_err", MW_err, 1'b1);
        chk("mis_mw_regwrite", MW_regWrite, 1'b0);
        clear_xm();
        tick();
        chk("mis_after_err", MW_err, 1'b0);

        // Timeout: mem_done withheld for 4 WAIT cycles
        XM_valid = 1'b1; XM_memRead = 1'b1; XM_aluOut = 16'h0050;
        XM_regSrc = 2'b01; XM_regWrite = 1'b1; XM_writeReg = 3'd4;
        #1;
        chk("to_req", bus_if.mem_req, 1'b1);
        tick();
        chk("to_w1_busy", mem_busy, 1'b1);
        tick();
        tick();
        chk("to_w3_busy", mem_busy, 1'b1);
        tick();
        chk("to_w4_busy", mem_busy, 1'b0);
        chk("to_w4_mw_valid", MW_valid, 1'b0);
        tick();
        chk("to_mw_valid", MW_valid, 1'b1);
        chk("to_mw_err", MW_err, 1'b1);
        chk("to_mw_regwrite", MW_regWrite, 1'b0);
        clear_xm();
        bus_if.mem_done = 1'b1; bus_if.mem_rdata = 16'h5555;
        #1;
        chk("late_done_busy", mem_busy, 1'b0);
        chk("late_done_req", bus_if.mem_req, 1'b0);
        tick();
        bus_if.mem_done = 1'b0; bus_if.mem_rdata = 16'h0000;
        chk("late_done_mw_valid", MW_valid, 1'b0);

        // mem_done in the timeout cycle completes normally
        XM_valid = 1'b1; XM_memRead = 1'b1; XM_aluOut = 16'h0060;
        XM_regSrc = 2'b01; XM_regWrite = 1'b1; XM_writeReg = 3'd7;
        #1;
        chk("tie_req", bus_if.mem_req, 1'b1);
        tick();
        tick();
        tick();
        tick();
        bus_if.mem_done = 1'b1; bus_if.mem_rdata = 16'hCAFE;
        tick();
        bus_if.mem_done = 1'b0; bus_if.mem_rdata = 16'h0000;
        chk("tie_mw_valid", MW_valid, 1'b1);
        chk("tie_mw_err", MW_err, 1'b0);
        chk("tie_mw_wb", MW_wbData, 16'hCAFE);
        chk("tie_mw_reg", MW_writeReg, 3'd7);
        clear_xm();

        // Reset while an access is outstanding
        XM_valid = 1'b1; XM_memRead = 1'b1; XM_aluOut = 16'h0070;
        XM_regSrc = 2'b01; XM_regWrite = 1'b1; XM_writeReg = 3'd1;
        tick();
        chk("rw_busy", mem_busy, 1'b1);
        rst = 1'b0;
        clear_xm();
        #1;
        chk("rw_busy_rst", mem_busy, 1'b0);
        chk("rw_addr_rst", bus_if.mem_addr, 16'h0000);
        chk("rw_wb_rst", MW_wbData, 16'h0000);
        chk("rw_valid_rst", MW_valid, 1'b0);
        #1;
        rst = 1'b1;
        bus_if.mem_done = 1'b1;
        tick();
        bus_if.mem_done = 1'b0;
        chk("rw_no_output", MW_valid, 1'b0);

        // Halt, then loads are ignored
        XM_valid = 1'b1; XM_halt = 1'b1; XM_aluOut = 16'h0002;
        tick();
        chk("halt_mw_valid", MW_valid, 1'b1);
        chk("halt_mw_halt", MW_halt, 1'b1);
        chk("halt_not_yet", halted, 1'b0);
        clear_xm();
        tick();
        chk("halted_set", halted, 1'b1);
        chk("halt_mw_halt_clr", MW_halt, 1'b0);
        req_snap = req_total;
        XM_valid = 1'b1; XM_memRead = 1'b1; XM_aluOut = 16'h0080;
        XM_regSrc = 2'b01; XM_regWrite = 1'b1;
        #1;
        chk("post_halt_req", bus_if.mem_req, 1'b0);
        chk("post_halt_busy", mem_busy, 1'b0);
        tick();
        chk("post_halt_mw_valid", MW_valid, 1'b0);
        tick();
        chk("post_halt_req_cycles", 16'(req_total - req_snap), 16'd0);
        chk("post_halt_sticky", halted, 1'b1);
        clear_xm();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline, sitting between the execute/memory pipe register and writeback. It turns each XM-stage instruction into at most one data-memory request over a variable-latency request/done handshake. While an access is outstanding it stalls upstream, and it produces the registered MW pipe outputs, including the selected writeback value, that the writeback stage consumes.

## Interface
- `TIMEOUT`, default 64: maximum WAIT cycles before an access is abandoned; 0 disables the timeout.
- `clk`  in  1  single clock; all state is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- `XM_valid`  in  1  XM slot holds a real instruction.
- `XM_aluOut`  in  16  data address, or ALU result.
- `XM_writeData`  in  16  store data.
- `XM_pc_inc`  in  16  PC+2, used for link writeback.
- `XM_specOps`  in  16  special-op result.
- `XM_memRead`, `XM_memWrite`  in  1 each  load and store.
- `XM_regSrc`  in  2  writeback select: 00 ALU, 01 memory, 10 pc_inc, 11 specOps.
- `XM_regWrite`  in  1  register write enable.
- `XM_writeReg`  in  3  destination register.
- `XM_halt`  in  1  halt instruction.
- `mem_req`  out  1  one-cycle request strobe.
- `mem_wr`  out  1  request is a store.
- `mem_addr`  out  16  request address.
- `mem_wdata`  out  16  store data.
- `mem_done`  in  1  access complete.
- `mem_rdata`  in  16  load data, valid while `mem_done` is high.
- `mem_busy`  out  1  stall upstream; XM must hold its values.
- `MW_valid`, `MW_regWrite`, `MW_halt`, `MW_err`  out  1 each  registered writeback controls.
- `MW_wbData`  out  16  registered writeback value.
- `MW_writeReg`  out  3  registered destination register.
- `halted`  out  1  sticky; set once `MW_halt` has been emitted.

## Operation
- Access condition: `XM_valid & (XM_memRead | XM_memWrite) & ~halted`.
  - If both `XM_memRead` and `XM_memWrite` are set, treat the access as a store.
- Misaligned access (`XM_aluOut[0]` = 1):
  - No request is issued.
  - Next cycle: `MW_valid`=1, `MW_err`=1, `MW_regWrite`=0.
- FSM, state IDLE:
  - Aligned access: `mem_req`=1 combinationally for that cycle. `mem_wr` = store. `mem_addr` = `XM_aluOut`. `mem_wdata` = `XM_writeData`.
  - Go to WAIT and clear the timeout counter.
  - Non-memory valid instruction: register the MW outputs directly; stay in IDLE.
  - `mem_done` in IDLE is ignored.
- FSM, state WAIT:
  - `mem_req`=0; `mem_addr`, `mem_wr` and `mem_wdata` hold their issued values.
  - Counter increments each cycle.
  - `mem_done`=1: capture the writeback value (`mem_rdata` when `XM_regSrc`=01) into MW; go to IDLE.
  - Counter reaches `TIMEOUT` (when `TIMEOUT` ≠ 0) before `mem_done`: emit `MW_valid`=1, `MW_err`=1, `MW_regWrite`=0; go to IDLE.
- `mem_busy` = (IDLE & aligned access) | (WAIT & ~`mem_done` & ~timeout).
  - Upstream advances in the same cycle that `mem_done` arrives.
- Writeback select: 00 → `XM_aluOut`; 01 → `mem_rdata` (latched on `mem_done`); 10 → `XM_pc_inc`; 11 → `XM_specOps`.
- Bubbles:
  - Any cycle without a completing instruction loads MW with `MW_valid`=0, `MW_regWrite`=0, `MW_halt`=0, `MW_err`=0.
  - `MW_wbData` and `MW_writeReg` may hold stale values during a bubble.
- Stores complete with `MW_regWrite` forced to 0.
- Halt:
  - A valid halt completes like a non-memory instruction with `MW_halt`=1.
  - `halted` sets on the following edge.
  - After that, every `XM_valid` is ignored: no requests, only bubbles.

## Timing
- Reset values (asynchronous, while `rst`=0): state IDLE, counter 0, `halted`=0, all MW outputs 0.
  - `mem_req`=0 and `mem_busy`=0, since the XM inputs are reset upstream.
- Reset during WAIT abandons the access; no MW output is produced for it.
- Latency, non-memory instruction: MW valid on the edge after the XM cycle (1 cycle).
- Latency, memory access: request cycle plus N ≥ 1 WAIT cycles; MW valid on the edge that samples `mem_done`. Minimum is 2 cycles.
- `mem_req` is never high for two consecutive cycles.
- At most one request is outstanding at any time.
- A new request may issue in the cycle immediately after `mem_done`.
- `mem_done` and timeout in the same cycle: `mem_done` wins and the access completes normally.

## Test plan
- ALU op: `XM_aluOut`=0x1234, `XM_regSrc`=00, `XM_regWrite`=1, `XM_writeReg`=3 → next cycle `MW_valid`=1, `MW_wbData`=0x1234, `MW_writeReg`=3; `mem_busy` never asserted.
- Load at 0x0040, `mem_done` after 3 WAIT cycles with `mem_rdata`=0xBEEF → `mem_req` high for exactly 1 cycle; `mem_busy` high for 3 cycles; then `MW_wbData`=0xBEEF, `MW_regWrite`=1.
- Back-to-back store then load:
  - Store 0x00AA to 0x0010, done in 1 cycle, then load → second `mem_req` in the cycle after the first `mem_done`.
  - Store gives `MW_regWrite`=0.
- Misaligned load at 0x0041 → no `mem_req`; next cycle `MW_err`=1, `MW_regWrite`=0.
- `TIMEOUT`=4, `mem_done` withheld → after 4 WAIT cycles `MW_err`=1 and state returns to IDLE; a late `mem_done` in IDLE is ignored.
- Reset in WAIT: drive `rst`=0 mid-access → all outputs 0 immediately with no clock edge. After a halt, `halted`=1 and later valid loads issue no `mem_req`.
